// File: rtl/tpu_tile_ctrl.sv
// Tiled matmul controller: walks every MxN output tile, streams K operand pairs, writes masked C rows.
// Latency: 1 + K + W + ARRAY_SIZE + 1 cycles per tile, plus one DONE cycle; zero dimensions finish in one cycle.
// Backpressure: none; new requests are ignored while busy, and the WAIT state stalls on sa_done.
module tpu_tile_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    K,
    input  logic [7:0]                    M,
    input  logic [7:0]                    N,
    output logic                          busy,
    output logic                          done_o,
    output logic [ADDR_BITS-1:0]          A_index,
    input  logic [DATA_BITS-1:0]          A_data_out,
    output logic [ADDR_BITS-1:0]          B_index,
    input  logic [DATA_BITS-1:0]          B_data_out,
    output logic                          sa_clear,
    output logic                          sa_in_valid,
    output logic [DATA_BITS-1:0]          sa_a_data,
    output logic [DATA_BITS-1:0]          sa_b_data,
    input  logic                          sa_done,
    output logic [$clog2(ARRAY_SIZE)-1:0] sa_row_sel,
    input  logic [DATAC_BITS-1:0]         sa_row_data,
    output logic                          C_wr_en,
    output logic [ADDR_BITS-1:0]          C_index,
    output logic [DATAC_BITS-1:0]         C_data_in
);
    localparam int RW       = $clog2(ARRAY_SIZE);
    localparam int ACC_BITS = DATAC_BITS / ARRAY_SIZE;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, WRITE, NEXT, DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     k_len, m_len, n_len, mt_tot, nt_tot;
    logic [7:0]     mt, nt, k;
    logic [RW-1:0]  r;
    logic           feed_q;
    logic           zero_dim, k_last, r_last, nt_last, mt_last;
    logic [8:0]     m_round, n_round;
    logic [ADDR_BITS-1:0] row_base, col_base;

    assign zero_dim = (K == 8'd0) || (M == 8'd0) || (N == 8'd0);
    assign m_round  = {1'b0, M} + 9'(ARRAY_SIZE - 1);
    assign n_round  = {1'b0, N} + 9'(ARRAY_SIZE - 1);
    assign k_last   = (k == k_len - 8'd1);
    assign r_last   = (r == RW'(ARRAY_SIZE - 1));
    assign nt_last  = (nt == nt_tot - 8'd1);
    assign mt_last  = (mt == mt_tot - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = zero_dim ? DONE : CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED:    if (k_last) state_nxt = WAIT;
            WAIT:    if (sa_done) state_nxt = WRITE;
            WRITE:   if (r_last) state_nxt = NEXT;
            NEXT:    state_nxt = (nt_last && mt_last) ? DONE : CLEAR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_len  <= '0;
            m_len  <= '0;
            n_len  <= '0;
            mt_tot <= '0;
            nt_tot <= '0;
            mt     <= '0;
            nt     <= '0;
            k      <= '0;
            r      <= '0;
            feed_q <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the valid is delayed to match.
            feed_q <= (state == FEED);
            case (state)
                IDLE: if (in_valid) begin
                    k_len  <= K;
                    m_len  <= M;
                    n_len  <= N;
                    mt_tot <= 8'(m_round >> RW);
                    nt_tot <= 8'(n_round >> RW);
                    mt     <= '0;
                    nt     <= '0;
                end
                CLEAR: k <= '0;
                FEED:  k <= k + 8'd1;
                WAIT:  if (sa_done) r <= '0;
                WRITE: r <= r + RW'(1);
                NEXT: begin
                    if (nt_last) begin
                        nt <= '0;
                        mt <= mt + 8'd1;
                    end else begin
                        nt <= nt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign row_base = ADDR_BITS'(mt) * ADDR_BITS'(ARRAY_SIZE) + ADDR_BITS'(r);
    assign col_base = ADDR_BITS'(nt) * ADDR_BITS'(ARRAY_SIZE);

    always_comb begin
        A_index    = '0;
        B_index    = '0;
        sa_row_sel = '0;
        C_wr_en    = 1'b0;
        C_index    = '0;
        C_data_in  = '0;
        if (state == FEED) begin
            A_index = ADDR_BITS'(mt) * ADDR_BITS'(k_len) + ADDR_BITS'(k);
            B_index = ADDR_BITS'(nt) * ADDR_BITS'(k_len) + ADDR_BITS'(k);
        end
        if (state == WRITE) begin
            sa_row_sel = r;
            C_wr_en    = (row_base < ADDR_BITS'(m_len));
            C_index    = row_base * ADDR_BITS'(nt_tot) + ADDR_BITS'(nt);
            // Columns beyond N in a partial tile carry garbage from the array and are zeroed.
            for (int c = 0; c < ARRAY_SIZE; c++) begin
                if (col_base + ADDR_BITS'(c) < ADDR_BITS'(n_len))
                    C_data_in[ACC_BITS*c +: ACC_BITS] = sa_row_data[ACC_BITS*c +: ACC_BITS];
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done_o      = (state == DONE);
    assign sa_clear    = (state == CLEAR);
    assign sa_in_valid = feed_q;
    assign sa_a_data   = A_data_out;
    assign sa_b_data   = B_data_out;
endmodule
